// File: rtl/fwd_pkg.sv
// Shared definitions for the operand forwarding tracker:
// opcodes, write classes and the per-stage entry layout.
package fwd_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int RD_W  = 5;
  localparam int CLS_W = 2;

  typedef enum logic [CLS_W-1:0] {
    CLS_NONE = 2'd0,
    CLS_MAIN = 2'd1,
    CLS_LOAD = 2'd2,
    CLS_LINK = 2'd3
  } cls_e;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    cls_e            cls;
    logic            ready;
  } ent_meta_t;

endpackage

// File: rtl/fwd_class_decode.sv
// Maps an opcode to the class that selects which
// value the producer eventually writes back.
module fwd_class_decode
  import fwd_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls
);

  logic is_main;
  logic is_link;
  logic is_load;

  assign is_main = (opcode == OPC_LUI) ||
                   (opcode == OPC_AUIPC) ||
                   (opcode == OPC_OP_IMM) ||
                   (opcode == OPC_OP);
  assign is_link = (opcode == OPC_JAL) ||
                   (opcode == OPC_JALR);
  assign is_load = (opcode == OPC_LOAD);

  // One-hot opcode groups to write class
  always_comb begin
    cls = CLS_NONE;
    unique case (1'b1)
      is_main: cls = CLS_MAIN;
      is_link: cls = CLS_LINK;
      is_load: cls = CLS_LOAD;
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/forward_tracker.sv
// In-flight write tracker with youngest-first operand
// forwarding and load-use stall detection.
module forward_tracker
  import fwd_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [6:0]              issue_opcode,
  input  logic [4:0]              issue_rd,
  input  logic [XLEN-1:0]         issue_main,
  input  logic [XLEN-1:0]         issue_link,
  input  logic                    pipe_hold,
  input  logic                    kill,
  input  logic                    load_valid,
  input  logic [XLEN-1:0]         load_data,
  input  logic [NUM_SRC*5-1:0]    src_rs,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    stall
);

  ent_meta_t       meta_q [DEPTH];
  ent_meta_t       meta_d [DEPTH];
  ent_meta_t       pre_m  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [XLEN-1:0] pre_d  [DEPTH];

  cls_e            new_cls;
  ent_meta_t       new_meta;
  logic [XLEN-1:0] new_data;
  logic            fill;
  logic [NUM_SRC-1:0] pend;

  fwd_class_decode u_dec (
    .opcode (issue_opcode),
    .cls    (new_cls)
  );

  // Stage-0 candidate; non-writers and rd=x0 become bubbles
  always_comb begin
    new_meta = '0;
    new_data = '0;
    if (issue_valid && new_cls != CLS_NONE &&
        issue_rd != '0) begin
      new_meta.valid = 1'b1;
      new_meta.rd    = issue_rd;
      new_meta.cls   = new_cls;
      new_meta.ready = (new_cls != CLS_LOAD);
      if (new_cls == CLS_MAIN) new_data = issue_main;
      if (new_cls == CLS_LINK) new_data = issue_link;
    end
  end

  assign fill = load_valid &&
                meta_q[LOAD_STAGE].valid &&
                meta_q[LOAD_STAGE].cls == CLS_LOAD;

  // Apply kill and load fill in place, then shift or hold
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      pre_m[k] = meta_q[k];
      pre_d[k] = data_q[k];
    end
    pre_m[0].valid = meta_q[0].valid & ~kill;
    if (fill) begin
      pre_m[LOAD_STAGE].ready = 1'b1;
      pre_d[LOAD_STAGE]       = load_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      meta_d[k] = pre_m[k];
      data_d[k] = pre_d[k];
    end
    if (!pipe_hold) begin
      meta_d[0] = new_meta;
      data_d[0] = new_data;
      for (int k = 1; k < DEPTH; k++) begin
        meta_d[k] = pre_m[k-1];
        data_d[k] = pre_d[k-1];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        meta_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        meta_q[k] <= meta_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    logic [4:0]      rs;
    logic            hit;
    logic            rdy;
    logic [XLEN-1:0] dat;

    assign rs = src_rs[5*i +: 5];

    // Oldest-first scan so the youngest match wins
    always_comb begin
      hit = 1'b0;
      rdy = 1'b0;
      dat = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (rs != '0 && meta_q[k].valid &&
            meta_q[k].rd == rs) begin
          hit = 1'b1;
          rdy = meta_q[k].ready;
          dat = data_q[k];
        end
      end
    end

    assign fwd_hit[i] = hit;
    assign fwd_data[XLEN*i +: XLEN] = rdy ? dat : '0;
    assign pend[i] = hit & ~rdy;
  end

  assign stall = |pend;

endmodule

// File: tb/tb_forward_tracker.sv
// Randomized and directed bench for forward_tracker
// against a queue-based pipeline model.
module tb_forward_tracker;

  localparam int X  = 32;
  localparam int D  = 3;
  localparam int N  = 2;
  localparam int LS = 1;

  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JLR = 7'b1100111;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_OP  = 7'b0110011;
  localparam logic [6:0] O_BR  = 7'b1100011;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           issue_valid;
  logic [6:0]     issue_opcode;
  logic [4:0]     issue_rd;
  logic [X-1:0]   issue_main;
  logic [X-1:0]   issue_link;
  logic           pipe_hold;
  logic           kill;
  logic           load_valid;
  logic [X-1:0]   load_data;
  logic [N*5-1:0] src_rs;
  logic [N-1:0]   fwd_hit;
  logic [N*X-1:0] fwd_data;
  logic           stall;

  always #5 clk = ~clk;

  forward_tracker #(
    .XLEN(X), .DEPTH(D), .NUM_SRC(N), .LOAD_STAGE(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rd(issue_rd), .issue_main(issue_main),
    .issue_link(issue_link), .pipe_hold(pipe_hold),
    .kill(kill), .load_valid(load_valid),
    .load_data(load_data), .src_rs(src_rs),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall)
  );

  typedef struct {
    bit           v;
    int           rd;
    int           cls;
    logic [X-1:0] data;
    bit           rdy;
  } me_t;

  me_t pipe[$];
  int  total = 0;
  int  bad = 0;
  bit  chk_en = 1'b0;

  // 0 none, 1 main, 2 load, 3 link
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      O_LUI, O_AUI, O_IMM, O_OP: return 1;
      O_JAL, O_JLR:              return 3;
      O_LD:                      return 2;
      default:                   return 0;
    endcase
  endfunction

  function automatic me_t empty_e();
    me_t e;
    e.v = 0; e.rd = 0; e.cls = 0; e.data = '0; e.rdy = 0;
    return e;
  endfunction

  function automatic void m_clear();
    pipe.delete();
    for (int k = 0; k < D; k++) pipe.push_back(empty_e());
  endfunction

  task automatic chk(input string name,
                     input logic [X-1:0] act,
                     input logic [X-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Pipeline model: newest at the front, oldest retires
  always @(posedge clk or negedge rst_n) begin : model
    me_t e;
    int  c;
    if (!rst_n) begin
      m_clear();
    end else begin
      if (kill) begin
        e = pipe[0]; e.v = 0; pipe[0] = e;
      end
      if (load_valid && pipe[LS].v && pipe[LS].cls == 2) begin
        e = pipe[LS]; e.data = load_data; e.rdy = 1;
        pipe[LS] = e;
      end
      if (!pipe_hold) begin
        e = empty_e();
        c = cls_of(issue_opcode);
        if (issue_valid && c != 0 && issue_rd != 0) begin
          e.v = 1; e.rd = int'(issue_rd); e.cls = c;
          e.rdy = (c != 2);
          e.data = (c == 1) ? issue_main :
                   (c == 3) ? issue_link : '0;
        end
        pipe.push_front(e);
        void'(pipe.pop_back());
      end
    end
  end

  function automatic void m_look(input logic [4:0] rs,
                                 output bit h, output bit r,
                                 output logic [X-1:0] d);
    h = 0; r = 0; d = '0;
    if (rs != 0) begin
      for (int k = 0; k < D; k++) begin
        if (!h && pipe[k].v && pipe[k].rd == int'(rs)) begin
          h = 1;
          r = pipe[k].rdy;
          d = r ? pipe[k].data : '0;
        end
      end
    end
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    bit h, r, st;
    logic [X-1:0] d;
    if (chk_en) begin
      st = 0;
      for (int i = 0; i < N; i++) begin
        m_look(src_rs[5*i +: 5], h, r, d);
        st = st | (h & ~r);
        chk($sformatf("cyc_hit%0d", i), X'(fwd_hit[i]), X'(h));
        chk($sformatf("cyc_data%0d", i), fwd_data[X*i +: X], d);
      end
      chk("cyc_stall", X'(stall), X'(st));
    end
  end

  task automatic idle();
    issue_valid = 0; issue_opcode = '0; issue_rd = '0;
    issue_main = '0; issue_link = '0; pipe_hold = 0;
    kill = 0; load_valid = 0; load_data = '0;
  endtask

  task automatic iss(input logic [6:0] op, input logic [4:0] rd,
                     input logic [X-1:0] m, input logic [X-1:0] l);
    issue_valid = 1; issue_opcode = op; issue_rd = rd;
    issue_main = m; issue_link = l;
  endtask

  task automatic nx();
    @(negedge clk); #1;
  endtask

  task automatic pe();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int s,
                     input bit eh, input logic [X-1:0] ed,
                     input bit es);
    chk({name, "_hit"}, X'(fwd_hit[s]), X'(eh));
    chk({name, "_data"}, fwd_data[X*s +: X], ed);
    chk({name, "_stall"}, X'(stall), X'(es));
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{O_LUI, O_AUI, O_JAL, O_JLR, O_LD,
            O_ST, O_IMM, O_OP, O_BR, 7'h7F};
    m_clear();
    idle();
    rst_n = 0;
    src_rs = {5'd5, 5'd5};
    iss(O_OP, 5'd5, 32'h1, 32'h0);
    chk_en = 1;
    repeat (3) begin
      pe(); lit("rst", 0, 0, '0, 0);
    end

    nx(); idle(); rst_n = 1;
    pe(); lit("post_rst", 1, 0, '0, 0);

    nx(); iss(O_OP, 5'd5, 32'h1234, 32'h0);
    src_rs = {5'd0, 5'd5};
    pe(); lit("alu", 0, 1, 32'h1234, 0);
    lit("alu_rs0", 1, 0, '0, 0);
    nx(); idle();
    pe(); pe(); lit("alu_s2", 0, 1, 32'h1234, 0);
    pe(); lit("alu_gone", 0, 0, '0, 0);

    nx(); iss(O_OP, 5'd7, 32'hA, 32'h0);
    src_rs = {5'd0, 5'd7};
    pe();
    nx(); iss(O_OP, 5'd7, 32'hB, 32'h0);
    pe(); lit("prio", 0, 1, 32'hB, 0);
    nx(); idle(); repeat (3) pe();

    nx(); iss(O_LD, 5'd3, 32'h77, 32'h0);
    src_rs = {5'd0, 5'd3};
    pe(); lit("ld_use", 0, 1, '0, 1);
    nx(); idle();
    pe(); lit("ld_wait", 0, 1, '0, 1);
    nx(); load_valid = 1; load_data = 32'hDEAD;
    pe(); lit("ld_fill", 0, 1, 32'hDEAD, 0);
    nx(); idle(); repeat (3) pe();

    nx(); iss(O_JAL, 5'd1, 32'h0, 32'h104);
    src_rs = {5'd0, 5'd1};
    pe(); lit("jal", 0, 1, 32'h104, 0);
    nx(); idle(); pipe_hold = 1;
    repeat (3) begin
      pe(); lit("hold", 0, 1, 32'h104, 0);
    end
    nx(); kill = 1;
    pe(); lit("kill", 0, 0, '0, 0);
    nx(); idle(); repeat (3) pe();

    nx(); iss(O_ST, 5'd9, 32'h9, 32'h0);
    src_rs = {5'd10, 5'd9};
    pe();
    nx(); iss(O_BR, 5'd10, 32'h10, 32'h0);
    pe(); lit("store", 0, 0, '0, 0);
    lit("branch", 1, 0, '0, 0);
    nx(); iss(O_OP, 5'd0, 32'h55, 32'h0);
    src_rs = {5'd0, 5'd0};
    pe(); lit("rd0", 0, 0, '0, 0);
    nx(); idle(); repeat (3) pe();

    for (int i = 0; i < 3000; i++) begin
      nx();
      rst_n = !(i == 1500 || i == 2400);
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_opcode = ops[$urandom_range(0, 9)];
      issue_rd     = 5'($urandom_range(0, 7));
      issue_main   = $urandom;
      issue_link   = $urandom;
      pipe_hold    = ($urandom_range(0, 3) == 0);
      kill         = ($urandom_range(0, 6) == 0);
      load_valid   = ($urandom_range(0, 4) < 2);
      load_data    = $urandom;
      for (int s = 0; s < N; s++)
        src_rs[5*s +: 5] = 5'($urandom_range(0, 7));
    end

    nx(); idle(); rst_n = 1;
    pe(); nx();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
